// File: rtl/prbs_pkg.sv
// prbs_pkg: state encodings and shared constants for the PRBS checker.
// Imported by prbs_predictor and prbs_checker.
package prbs_pkg;

    localparam logic [1:0] SEED   = 2'd0;
    localparam logic [1:0] VERIFY = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;

    // x^4 + x^3 + 1
    localparam logic [3:0] DEF_TAPS = 4'b1100;

    localparam int ERR_CNT_W = 16;

endpackage

// File: rtl/prbs_predictor.sv
// prbs_predictor: shadow LFSR and next-bit prediction.
// The shift source is chosen by the checker FSM (received bit or prediction).
module prbs_predictor
    import prbs_pkg::*;
#(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] TAPS  = DEF_TAPS
) (
    input  logic clk,
    input  logic reset,
    input  logic shift_en,
    input  logic use_pred,
    input  logic in_bit,
    output logic p,
    output logic zero
);

    logic [WIDTH-1:0] r_q, r_d;

    assign p    = ^(r_q & TAPS);
    assign zero = (r_q == '0);

    always_comb begin
        r_d = r_q;
        if (shift_en) begin
            r_d = {r_q[WIDTH-2:0], use_pred ? p : in_bit};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q <= '0;
        end else begin
            r_q <= r_d;
        end
    end

endmodule

// File: rtl/prbs_checker.sv
// prbs_checker: self-synchronising PRBS receive checker with lock/loss FSM.
// Define PRBS_CHECKER_ERR_COUNT_EN to build the saturating error counter.
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int               WIDTH       = 4,
    parameter logic [WIDTH-1:0] TAPS        = DEF_TAPS,
    parameter int               LOCK_COUNT  = 8,
    parameter int               LOSS_THRESH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 in_bit,
    output logic                 locked,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [1:0]           state
);

    localparam int SW = $clog2(WIDTH + 1);
    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam int LW = $clog2(LOSS_THRESH + 1);

    localparam logic [SW-1:0] SEED_N = SW'(WIDTH);
    localparam logic [MW-1:0] LOCK_N = MW'(LOCK_COUNT);
    localparam logic [LW-1:0] LOSS_N = LW'(LOSS_THRESH);

    logic [1:0]    state_q, state_d;
    logic [SW-1:0] seed_cnt_q, seed_cnt_d;
    logic [MW-1:0] match_cnt_q, match_cnt_d;
    logic [LW-1:0] miss_cnt_q, miss_cnt_d;
    logic          locked_q, locked_d;
    logic          err_pulse_q, err_pulse_d;

    logic use_pred;
    logic p;
    logic zero;
    logic bad;

    prbs_predictor #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_pred (
        .clk      (clk),
        .reset    (reset),
        .shift_en (en),
        .use_pred (use_pred),
        .in_bit   (in_bit),
        .p        (p),
        .zero     (zero)
    );

    // Flywheel: once locked the reference runs on its own predictions
    assign use_pred = (state_q == LOCKED);
    assign bad      = (in_bit != p);

    always_comb begin
        state_d     = state_q;
        seed_cnt_d  = seed_cnt_q;
        match_cnt_d = match_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        err_pulse_d = 1'b0;
        if (en) begin
            unique case (1'b1)
                (state_q == SEED): begin
                    seed_cnt_d = seed_cnt_q + SW'(1);
                    if (seed_cnt_d == SEED_N) begin
                        state_d     = VERIFY;
                        seed_cnt_d  = '0;
                        match_cnt_d = '0;
                    end
                end
                (state_q == VERIFY): begin
                    if (!bad && !zero) begin
                        match_cnt_d = match_cnt_q + MW'(1);
                        if (match_cnt_d == LOCK_N) begin
                            state_d    = LOCKED;
                            miss_cnt_d = '0;
                        end
                    end else begin
                        state_d    = SEED;
                        seed_cnt_d = '0;
                    end
                end
                (state_q == LOCKED): begin
                    if (bad) begin
                        err_pulse_d = 1'b1;
                        miss_cnt_d  = miss_cnt_q + LW'(1);
                        if (miss_cnt_d == LOSS_N) begin
                            state_d    = SEED;
                            seed_cnt_d = '0;
                            miss_cnt_d = '0;
                        end
                    end else begin
                        miss_cnt_d = '0;
                    end
                end
                default: begin
                    state_d     = SEED;
                    seed_cnt_d  = '0;
                    match_cnt_d = '0;
                    miss_cnt_d  = '0;
                end
            endcase
        end
    end

    assign locked_d = (state_d == LOCKED);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= SEED;
            seed_cnt_q  <= '0;
            match_cnt_q <= '0;
            miss_cnt_q  <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            seed_cnt_q  <= seed_cnt_d;
            match_cnt_q <= match_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
        end
    end

`ifdef PRBS_CHECKER_ERR_COUNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_pulse_d && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_count = err_cnt_q;
`else
    assign err_count = '0;
`endif

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign state     = state_q;

endmodule
